// File: rtl/rom_sequencer_if.sv
// Instruction bus from the ROM sequencer to the mode select mux.
// master drives cpu_a/cpu_b/cpu_opcode/cpu_valid; slave observes them.
interface rom_sequencer_if;
    logic [7:0] cpu_a;
    logic [7:0] cpu_b;
    logic [2:0] cpu_opcode;
    logic       cpu_valid;

    modport master (
        output cpu_a,
        output cpu_b,
        output cpu_opcode,
        output cpu_valid
    );

    modport slave (
        input cpu_a,
        input cpu_b,
        input cpu_opcode,
        input cpu_valid
    );
endinterface

// File: rtl/rom_sequencer.sv
// Built-in ROM program source for CPU mode 1: steps pc through a 16-entry ROM.
// Ports: clk, reset (sync, active-high), mode, start, pause, bus (master), pc, done.
module rom_sequencer #(
    parameter int PROG_LEN    = 8,
    parameter int STEP_CYCLES = 4,
    parameter bit LOOP        = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mode,
    input  logic            start,
    input  logic            pause,
    rom_sequencer_if.master bus,
    output logic [3:0]      pc,
    output logic            done
);
    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [3:0]    LAST     = 4'(PROG_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    a_q, a_d;
    logic [7:0]    b_q, b_d;
    logic [2:0]    op_q, op_d;
    logic          valid_q, valid_d;

    logic [7:0]    rom_a;
    logic [7:0]    rom_b;
    logic [2:0]    rom_op;

    always_comb begin
        rom_op = pc_q[2:0];
        rom_a  = 8'h10 + {4'h0, pc_q};
        rom_b  = {pc_q, 4'h3};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        valid_d = 1'b0;

        if (!mode) begin
            // Leaving ROM mode clears everything so the mux sees a quiet bus.
            state_d = IDLE;
            pc_d    = '0;
            cnt_d   = '0;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    pc_d = '0;
                    if (start) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    a_d     = rom_a;
                    b_d     = rom_b;
                    op_d    = rom_op;
                    cnt_d   = CNT_LOAD;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
                HOLD: begin
                    if (pause) begin
                        state_d = HOLD;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else if (pc_q != LAST) begin
                        pc_d    = pc_q + 4'd1;
                        state_d = FETCH;
                    end else if (LOOP) begin
                        pc_d    = '0;
                        state_d = FETCH;
                    end else begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (start) begin
                        pc_d    = '0;
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_a      = a_q;
    assign bus.cpu_b      = b_q;
    assign bus.cpu_opcode = op_q;
    assign bus.cpu_valid  = valid_q;
    assign pc             = pc_q;
    assign done           = (state_q == DONE);
endmodule

// File: tb/tb_rom_sequencer.sv
// Testbench for rom_sequencer: scoreboarded instruction issue checks.
// Three instances cover default, short looping and 16-entry wrap configs.
module tb_rom_sequencer;
    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] pc;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mode0 = 1'b0, start0 = 1'b0, pause0 = 1'b0;
    logic mode1 = 1'b0, start1 = 1'b0, pause1 = 1'b0;
    logic mode2 = 1'b0, start2 = 1'b0, pause2 = 1'b0;
    logic [3:0] pc0, pc1, pc2;
    logic done0, done1, done2;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   t0 = 0;
    exp_t sb[$];

    rom_sequencer_if if0 ();
    rom_sequencer_if if1 ();
    rom_sequencer_if if2 ();

    rom_sequencer u0 (
        .clk(clk), .reset(reset), .mode(mode0), .start(start0),
        .pause(pause0), .bus(if0), .pc(pc0), .done(done0)
    );

    rom_sequencer #(.PROG_LEN(3), .STEP_CYCLES(1), .LOOP(1'b1)) u1 (
        .clk(clk), .reset(reset), .mode(mode1), .start(start1),
        .pause(pause1), .bus(if1), .pc(pc1), .done(done1)
    );

    rom_sequencer #(.PROG_LEN(16), .STEP_CYCLES(1), .LOOP(1'b1)) u2 (
        .clk(clk), .reset(reset), .mode(mode2), .start(start2),
        .pause(pause2), .bus(if2), .pc(pc2), .done(done2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(int i, int c);
        exp_t e;
        logic [3:0] ix;
        ix    = i[3:0];
        e.op  = ix[2:0];
        e.a   = 8'h10 + {4'h0, ix};
        e.b   = {ix, 4'h3};
        e.pc  = ix;
        e.cyc = c;
        return e;
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({if0.cpu_a, if0.cpu_b, if0.cpu_opcode, if0.cpu_valid, pc0, done0} !== 25'd0) begin
                n_bad++;
                $display("FAIL reset_hold: a=%h b=%h op=%h v=%b pc=%h done=%b, want all 0",
                         if0.cpu_a, if0.cpu_b, if0.cpu_opcode, if0.cpu_valid, pc0, done0);
            end
            mode0 = 1'($urandom_range(0, 1));
            start0 = 1'($urandom_range(0, 1));
            pause0 = 1'($urandom_range(0, 1));
            mode1 = 1'($urandom_range(0, 1));
            start1 = 1'($urandom_range(0, 1));
            mode2 = 1'($urandom_range(0, 1));
            start2 = 1'($urandom_range(0, 1));
        end
        reset = 1'b0;
        mode0 = 1'b1;
        start0 = 1'b0;
        pause0 = 1'b0;
        mode1 = 1'b0;
        start1 = 1'b0;
        mode2 = 1'b0;
        start2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({if0.cpu_a, if0.cpu_b, if0.cpu_opcode, if0.cpu_valid, pc0, done0} !== 25'd0) begin
                n_bad++;
                $display("FAIL reset_release: a=%h b=%h op=%h v=%b pc=%h done=%b, want all 0",
                         if0.cpu_a, if0.cpu_b, if0.cpu_opcode, if0.cpu_valid, pc0, done0);
            end
        end
    endtask

    task automatic test_program();
        exp_t e;
        @(negedge clk);
        t0 = cyc;
        start0 = 1'b1;
        for (int i = 0; i < 8; i++) sb.push_back(mk(i, t0 + 2 + 5 * i));
        while (cyc < t0 + 45) begin
            @(negedge clk);
            if (cyc == t0 + 10) start0 = 1'b0;
            if (if0.cpu_valid) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL prog_extra: valid at cyc %0d, none expected", cyc);
                end else begin
                    e = sb.pop_front();
                    if ({cyc, if0.cpu_opcode, if0.cpu_a, if0.cpu_b, pc0} !==
                        {e.cyc, e.op, e.a, e.b, e.pc}) begin
                        n_bad++;
                        $display("FAIL prog_issue: cyc=%0d op=%h a=%h b=%h pc=%h, want cyc=%0d op=%h a=%h b=%h pc=%h",
                                 cyc, if0.cpu_opcode, if0.cpu_a, if0.cpu_b, pc0,
                                 e.cyc, e.op, e.a, e.b, e.pc);
                    end
                end
            end
            if (cyc == t0 + 40) begin
                n_cmp++;
                if (done0 !== 1'b0) begin
                    n_bad++;
                    $display("FAIL prog_done_early: done=%b, want 0", done0);
                end
            end
            if (cyc == t0 + 41) begin
                n_cmp++;
                if ({done0, pc0} !== {1'b1, 4'd7}) begin
                    n_bad++;
                    $display("FAIL prog_done: done=%b pc=%h, want done=1 pc=7", done0, pc0);
                end
            end
            if (cyc == t0 + 45) begin
                n_cmp++;
                if ({done0, pc0, if0.cpu_opcode, if0.cpu_a, if0.cpu_b} !==
                    {1'b1, 4'd7, 3'd7, 8'h17, 8'h73}) begin
                    n_bad++;
                    $display("FAIL prog_done_hold: done=%b pc=%h op=%h a=%h b=%h, want 1 7 7 17 73",
                             done0, pc0, if0.cpu_opcode, if0.cpu_a, if0.cpu_b);
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL prog_missing: %0d issues not seen, want 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_done_restart();
        exp_t e;
        @(negedge clk);
        t0 = cyc;
        start0 = 1'b1;
        sb.push_back(mk(0, t0 + 2));
        sb.push_back(mk(1, t0 + 7));
        while (cyc < t0 + 9) begin
            @(negedge clk);
            if (cyc == t0 + 1) begin
                start0 = 1'b0;
                n_cmp++;
                if ({done0, pc0} !== {1'b0, 4'd0}) begin
                    n_bad++;
                    $display("FAIL restart_done_fall: done=%b pc=%h, want done=0 pc=0", done0, pc0);
                end
            end
            if (if0.cpu_valid) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL restart_extra: valid at cyc %0d, none expected", cyc);
                end else begin
                    e = sb.pop_front();
                    if ({cyc, if0.cpu_opcode, if0.cpu_a, if0.cpu_b, pc0} !==
                        {e.cyc, e.op, e.a, e.b, e.pc}) begin
                        n_bad++;
                        $display("FAIL restart_issue: cyc=%0d op=%h a=%h b=%h pc=%h, want cyc=%0d op=%h a=%h b=%h pc=%h",
                                 cyc, if0.cpu_opcode, if0.cpu_a, if0.cpu_b, pc0,
                                 e.cyc, e.op, e.a, e.b, e.pc);
                    end
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL restart_missing: %0d issues not seen, want 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_mode_drop();
        exp_t e;
        mode0 = 1'b0;
        start0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({if0.cpu_a, if0.cpu_b, if0.cpu_opcode, if0.cpu_valid, pc0, done0} !== 25'd0) begin
                n_bad++;
                $display("FAIL mode_drop: a=%h b=%h op=%h v=%b pc=%h done=%b, want all 0",
                         if0.cpu_a, if0.cpu_b, if0.cpu_opcode, if0.cpu_valid, pc0, done0);
            end
        end
        mode0 = 1'b1;
        t0 = cyc;
        sb.push_back(mk(0, t0 + 2));
        while (cyc < t0 + 2) begin
            @(negedge clk);
            if (cyc == t0 + 1) start0 = 1'b0;
            if (if0.cpu_valid) begin
                n_cmp++;
                e = sb.pop_front();
                if ({cyc, if0.cpu_opcode, if0.cpu_a, if0.cpu_b, pc0} !==
                    {e.cyc, e.op, e.a, e.b, e.pc}) begin
                    n_bad++;
                    $display("FAIL mode_restart: cyc=%0d op=%h a=%h b=%h pc=%h, want cyc=%0d op=%h a=%h b=%h pc=%h",
                             cyc, if0.cpu_opcode, if0.cpu_a, if0.cpu_b, pc0,
                             e.cyc, e.op, e.a, e.b, e.pc);
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL mode_restart_missing: %0d issues not seen, want 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_pause();
        exp_t e;
        exp_t last;
        last = mk(0, 0);
        for (int i = 1; i < 8; i++) begin
            sb.push_back(mk(i, t0 + 2 + 5 * i + ((i >= 3) ? 3 : 0)));
        end
        while (cyc < t0 + 46) begin
            @(negedge clk);
            if (if0.cpu_valid) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL pause_extra: valid at cyc %0d, none expected", cyc);
                end else begin
                    e = sb.pop_front();
                    last = e;
                    if ({cyc, if0.cpu_opcode, if0.cpu_a, if0.cpu_b, pc0} !==
                        {e.cyc, e.op, e.a, e.b, e.pc}) begin
                        n_bad++;
                        $display("FAIL pause_issue: cyc=%0d op=%h a=%h b=%h pc=%h, want cyc=%0d op=%h a=%h b=%h pc=%h",
                                 cyc, if0.cpu_opcode, if0.cpu_a, if0.cpu_b, pc0,
                                 e.cyc, e.op, e.a, e.b, e.pc);
                    end
                end
            end else begin
                n_cmp++;
                if ({if0.cpu_opcode, if0.cpu_a, if0.cpu_b} !== {last.op, last.a, last.b}) begin
                    n_bad++;
                    $display("FAIL pause_stable: cyc=%0d op=%h a=%h b=%h, want op=%h a=%h b=%h",
                             cyc, if0.cpu_opcode, if0.cpu_a, if0.cpu_b, last.op, last.a, last.b);
                end
            end
            if (cyc == t0 + 43 || cyc == t0 + 44) begin
                n_cmp++;
                if (done0 !== (cyc == t0 + 44)) begin
                    n_bad++;
                    $display("FAIL pause_done: cyc=%0d done=%b, want %b", cyc, done0, cyc == t0 + 44);
                end
            end
            pause0 = (cyc >= t0 + 13 && cyc <= t0 + 15);
        end
        pause0 = 1'b0;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL pause_missing: %0d issues not seen, want 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_loop();
        exp_t e;
        logic saw_done;
        saw_done = 1'b0;
        @(negedge clk);
        t0 = cyc;
        mode1 = 1'b1;
        start1 = 1'b1;
        for (int i = 0; i < 5; i++) sb.push_back(mk(i % 3, t0 + 2 + 2 * i));
        while (cyc < t0 + 11) begin
            @(negedge clk);
            if (cyc == t0 + 1) start1 = 1'b0;
            if (done1) saw_done = 1'b1;
            if (if1.cpu_valid) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL loop_extra: valid at cyc %0d, none expected", cyc);
                end else begin
                    e = sb.pop_front();
                    if ({cyc, if1.cpu_opcode, if1.cpu_a, if1.cpu_b, pc1} !==
                        {e.cyc, e.op, e.a, e.b, e.pc}) begin
                        n_bad++;
                        $display("FAIL loop_issue: cyc=%0d op=%h a=%h b=%h pc=%h, want cyc=%0d op=%h a=%h b=%h pc=%h",
                                 cyc, if1.cpu_opcode, if1.cpu_a, if1.cpu_b, pc1,
                                 e.cyc, e.op, e.a, e.b, e.pc);
                    end
                end
            end
        end
        mode1 = 1'b0;
        n_cmp++;
        if (saw_done !== 1'b0) begin
            n_bad++;
            $display("FAIL loop_done: done seen=%b, want 0", saw_done);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL loop_missing: %0d issues not seen, want 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_wrap16();
        exp_t e;
        @(negedge clk);
        t0 = cyc;
        mode2 = 1'b1;
        start2 = 1'b1;
        for (int i = 0; i < 17; i++) sb.push_back(mk(i % 16, t0 + 2 + 2 * i));
        while (cyc < t0 + 35) begin
            @(negedge clk);
            if (cyc == t0 + 1) start2 = 1'b0;
            if (if2.cpu_valid) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL wrap_extra: valid at cyc %0d, none expected", cyc);
                end else begin
                    e = sb.pop_front();
                    if ({cyc, if2.cpu_opcode, if2.cpu_a, if2.cpu_b, pc2} !==
                        {e.cyc, e.op, e.a, e.b, e.pc}) begin
                        n_bad++;
                        $display("FAIL wrap_issue: cyc=%0d op=%h a=%h b=%h pc=%h, want cyc=%0d op=%h a=%h b=%h pc=%h",
                                 cyc, if2.cpu_opcode, if2.cpu_a, if2.cpu_b, pc2,
                                 e.cyc, e.op, e.a, e.b, e.pc);
                    end
                end
            end
        end
        mode2 = 1'b0;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL wrap_missing: %0d issues not seen, want 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        t0 = cyc;
        start0 = 1'b1;
        while (cyc < t0 + 4) begin
            @(negedge clk);
            if (cyc == t0 + 1) start0 = 1'b0;
        end
        n_cmp++;
        if ({if0.cpu_opcode, if0.cpu_a, if0.cpu_b, done0} !== {3'd0, 8'h10, 8'h03, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_mid_pre: op=%h a=%h b=%h done=%b, want 0 10 03 0",
                     if0.cpu_opcode, if0.cpu_a, if0.cpu_b, done0);
        end
        reset = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({if0.cpu_a, if0.cpu_b, if0.cpu_opcode, if0.cpu_valid, pc0, done0} !== 25'd0) begin
            n_bad++;
            $display("FAIL reset_mid: a=%h b=%h op=%h v=%b pc=%h done=%b, want all 0",
                     if0.cpu_a, if0.cpu_b, if0.cpu_opcode, if0.cpu_valid, pc0, done0);
        end
        reset = 1'b0;
        start0 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({if0.cpu_a, if0.cpu_b, if0.cpu_opcode, if0.cpu_valid, pc0, done0} !== 25'd0) begin
            n_bad++;
            $display("FAIL reset_mid_idle: a=%h b=%h op=%h v=%b pc=%h done=%b, want all 0",
                     if0.cpu_a, if0.cpu_b, if0.cpu_opcode, if0.cpu_valid, pc0, done0);
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_done_restart();
        test_mode_drop();
        test_pause();
        test_loop();
        test_wrap16();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rom_sequencer.md
# rom_sequencer

Internal program source for CPU mode 1 (built-in ROM execution). Steps a program counter through a fixed 16-entry instruction ROM and presents each entry as `cpu_a`, `cpu_b` and `cpu_opcode` for the mode select mux, which forwards them to the ALU when `mode = 1`. Adds start/pause control, a programmable dwell time per instruction and a one-cycle `cpu_valid` strobe per issued instruction.

## Interface

Parameters:
- `PROG_LEN`, 8: number of ROM entries executed, 1..16.
- `STEP_CYCLES`, 4: cycles each instruction is held in HOLD, ≥1.
- `LOOP`, 0: 1 = wrap to entry 0 after the last entry; 0 = stop in DONE.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high; overrides every other input.
- `mode`  in  1  same mode signal as the select mux; 1 = ROM execution enabled.
- `start`  in  1  level, sampled each cycle; begins or restarts the program.
- `pause`  in  1  freezes sequencing while high.
- `cpu_a`  out  8  operand A of the current instruction (registered).
- `cpu_b`  out  8  operand B (registered).
- `cpu_opcode`  out  3  opcode (registered).
- `cpu_valid`  out  1  one-cycle strobe on each newly issued instruction.
- `pc`  out  4  index of the current/next ROM entry.
- `done`  out  1  high while in DONE.

## Operation

- ROM entry i (0..15), combinational from `pc`: opcode = i[2:0]; a = 8'h10 + i; b = {i[3:0], 4'h3}.
- States: IDLE, FETCH, HOLD, DONE. Reset → IDLE.
- IDLE: `pc` = 0. `mode & start` → FETCH.
- FETCH (1 cycle): on exit, load `cpu_a/b/opcode` from ROM[`pc`], load the hold counter with STEP_CYCLES−1, assert `cpu_valid` for the next cycle, and go to HOLD.
- HOLD: if `pause`, hold everything. Otherwise, if counter ≠ 0, decrement. If counter = 0:
  - `pc` ≠ PROG_LEN−1: `pc` ← `pc`+1, go to FETCH.
  - last entry with LOOP=1: `pc` ← 0, go to FETCH.
  - last entry with LOOP=0: go to DONE.
- DONE: `done` = 1. `pc` and outputs hold the last instruction. `start` (with `mode`=1) sets `pc` ← 0 and goes to FETCH.
- `start` in FETCH/HOLD is ignored; there is no restart mid-program.
- `mode` = 0 in any state: next cycle IDLE, `pc` = 0, `cpu_a/b/opcode` = 0, `cpu_valid` = 0, `done` = 0.
- Priority: `reset` > `mode`=0 > `pause` > `start` > normal sequencing.
- `pause` in IDLE, FETCH or DONE has no effect. FETCH always completes.

## Timing

- Reset values: `cpu_a` = 0, `cpu_b` = 0, `cpu_opcode` = 0, `cpu_valid` = 0, `pc` = 0, `done` = 0. Reset mid-program aborts immediately; state is IDLE after the edge.
- `start` sampled high at edge E0 → FETCH during the next cycle → outputs for entry 0 and `cpu_valid` visible after edge E1.
- Instruction period without pause = STEP_CYCLES + 1 cycles, i.e. `cpu_valid` pulses every STEP_CYCLES+1 cycles.
- Each cycle of `pause` high during HOLD adds exactly one cycle to the period.
- Outputs stay stable from issue until the next issue, including across FETCH.
- `done` rises 1 cycle after the final HOLD cycle.
- With PROG_LEN=16, `pc` wraps 15→0 when LOOP=1.

## Test plan

- Reset with all inputs toggling → all outputs 0 and IDLE. After reset release with `start`=0, outputs remain 0.
- `mode`=1, single `start` pulse, defaults → `cpu_valid` 2 cycles after the start edge, then every 5 cycles. Entry 0 = op 0, a 0x10, b 0x03. Entry 3 = op 3, a 0x13, b 0x33. After entry 7 (op 7, a 0x17, b 0x73), `done`=1 with `pc`=7 held.
- LOOP=1, PROG_LEN=3, STEP_CYCLES=1 → opcodes 0,1,2,0,1 with `cpu_valid` every 2 cycles and `done` never set. A PROG_LEN=16 run shows entry 15 = op 7, a 0x1F, b 0xF3, then wraps to 0.
- `pause` held 3 cycles in HOLD of entry 2 → entry 3's `cpu_valid` arrives exactly 3 cycles late, and outputs are unchanged during the pause.
- `mode` dropped mid-HOLD with `start`=1 → next cycle outputs 0, `pc`=0, no `cpu_valid`. Re-raising `mode` with `start` restarts from entry 0.
- In DONE, `start` → program reruns from entry 0 and `done` falls. `reset` asserted mid-HOLD → all outputs 0 on the next cycle.
